tcm_lsu: RTL
============

# tcm_lsu

Load/store adapter between the core's memory stage and the word-wide tightly coupled memory (`tcm`). It accepts one byte/halfword/word request at a time over a valid/ready handshake and drives the TCM select/address/byte-enable/data lines. It then extracts and sign- or zero-extends the read lane from the TCM's registered output and returns a response over a second valid/ready handshake. One request is outstanding at a time.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, default 8: TCM word-address width. Must match the attached TCM.

Ports:
- `i_clk`  in  1  single clock, rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_req_valid`  in  1  request present
- `o_req_ready`  out  1  request accepted on `i_req_valid & o_req_ready` at the clock edge
- `i_req_addr`  in  32  byte address; bits above `MEM_ADDR_WIDTH+1` ignored (aliasing)
- `i_req_we`  in  1  1 = store, 0 = load
- `i_req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- `i_req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `i_req_wdata`  in  32  store data, right-aligned
- `o_rsp_valid`  out  1  response present
- `i_rsp_ready`  in  1  response consumed on `o_rsp_valid & i_rsp_ready`
- `o_rsp_data`  out  32  load result; 0 for stores and errors
- `o_rsp_err`  out  1  access fault (see Configuration)
- `o_tcm_sel`  out  1  TCM select
- `o_tcm_addr`  out  `MEM_ADDR_WIDTH`  TCM word address, equal to `req_addr[MEM_ADDR_WIDTH+1:2]`
- `o_tcm_write`  out  4  TCM byte write enables
- `o_tcm_data`  out  32  TCM write data
- `i_tcm_ack`  in  1  TCM acknowledge
- `i_tcm_data`  in  32  TCM registered read data, valid the cycle after a selected edge

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `o_req_ready=1`.
  - On accept, register addr/we/size/unsigned/wdata and go to ACCESS.
- ACCESS:
  - `o_tcm_sel=1`; addr, write and data are driven from the registered request.
  - If `i_tcm_ack=1`, go to RESP; otherwise stay in ACCESS with all TCM outputs held.
- RESP:
  - `o_rsp_valid=1`; `o_tcm_sel=0`, so the TCM output register holds.
  - On `i_rsp_ready`, go to IDLE.
  - `o_req_ready = i_rsp_ready` in RESP. A simultaneous accept goes directly to ACCESS.
- Store lane generation (offset `o = addr[1:0]`):
  - Byte: `o_tcm_write = 4'b0001 << o`, `o_tcm_data = {4{wdata[7:0]}}`.
  - Half: `o_tcm_write = 4'b0011 << (2*addr[1])`, `o_tcm_data = {2{wdata[15:0]}}`.
  - Word: `o_tcm_write = 4'b1111`, data passed through.
  - Loads drive `o_tcm_write = 0`.
- Load extraction:
  - Combinational from `i_tcm_data` in RESP.
  - Byte lane = `o`; half lane = `addr[1]`.
  - Extend per `i_req_unsigned`, as registered at accept.
- `o_rsp_err=0` unless `MISALIGN_TRAP_EN` is defined.

## Timing
- Reset:
  - While `i_reset=1`, all outputs are 0, including `o_req_ready` and `o_tcm_sel`.
  - The first cycle after reset is IDLE with `o_req_ready=1`.
- Reset mid-operation:
  - `o_tcm_sel` is gated with `~i_reset`, so a store pending in ACCESS at the reset edge is not written.
  - A pending response is discarded.
- Latency with TCM ack tied to select: accept at edge N, ACCESS during N..N+1, `o_rsp_valid` from N+1.
- Throughput: one request per 2 cycles with `i_rsp_ready` held high.
- Response backpressure: `o_rsp_data` stays stable while `o_rsp_valid & ~i_rsp_ready`. This holds because the TCM is not reselected.
- Request inputs are sampled only at the accept edge and may change afterwards.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - The following set `o_rsp_err=1`: half with `addr[0]=1`, word with `addr[1:0]!=0`, and size 11.
  - Such requests skip ACCESS: accept at edge N, then RESP from N+1 with data 0.
  - `o_tcm_sel` is never asserted for them.
- Not defined:
  - Offsets are force-aligned: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - Size 11 is treated as word.
  - `o_rsp_err` is tied to 0.

## Test plan
- Reset → `o_req_ready=0` and `o_tcm_sel=0` during reset; `o_req_ready=1` on the first cycle after reset.
- Word store 0xDEADBEEF to 0x10, then unsigned byte load from 0x13 → `o_tcm_write=4'b1111`, `o_tcm_addr=4`; load returns 0x000000DE. Signed byte load from 0x13 returns 0xFFFFFFDE.
- Half store 0x8001 to 0x22, then signed half load from 0x22 → `o_tcm_write=4'b1100` and `o_tcm_data=0x80018001`; load returns 0xFFFF8001. Bytes at 0x20/0x21 are unchanged.
- Backpressure: hold `i_rsp_ready=0` for 5 cycles → `o_rsp_valid` and `o_rsp_data` are stable, `o_req_ready=0`, `o_tcm_sel=0`. Then `i_rsp_ready=1` with a new request → accepted in the same cycle.
- Assert reset during ACCESS of a byte store of 0x55 to 0x40 → a subsequent load from 0x40 returns the old value.
- With `MISALIGN_TRAP_EN`, word load from 0x06 → `o_rsp_valid` one cycle after accept with `o_rsp_err=1` and data 0; `o_tcm_sel` never asserted. Without the macro, the same request returns the word at 0x04 with `err=0`.

Source files
------------

// File: rtl/tcm_lsu.sv
// Load/store adapter between the memory stage and a word-wide TCM; one request in flight.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned and reserved-size accesses.
module tcm_lsu #(
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [31:0]               i_req_addr,
    input  logic                      i_req_we,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_unsigned,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [31:0]               o_rsp_data,
    output logic                      o_rsp_err,
    output logic                      o_tcm_sel,
    output logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr,
    output logic [3:0]                o_tcm_write,
    output logic [31:0]               o_tcm_data,
    input  logic                      i_tcm_ack,
    input  logic [31:0]               i_tcm_data
);
    localparam int AW = MEM_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic            req_rdy;
    logic            accept;
    logic            req_mis;
    logic            access;
    logic            resp;

    logic [AW-1:0]   addr_p0;
    logic            we_p0;
    logic [1:0]      size_p0;
    logic            uns_p0;
    logic [31:0]     wdata_p0;
    logic            err_p0;

    logic            unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[31:AW];

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction
    assign req_mis = misaligned(i_req_size, i_req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    // Half uses only addr[1] and word/reserved ignore the offset, which force-aligns them.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic uns, input logic [31:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   r = uns ? $signed({24'b0, b}) : 32'(b);
            2'b01:   r = uns ? $signed({16'b0, h}) : 32'(h);
            default: r = $signed(d);
        endcase
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Request capture stage: inputs are only looked at on the accept edge.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_p0  <= i_req_addr[AW-1:0];
            we_p0    <= i_req_we;
            size_p0  <= i_req_size;
            uns_p0   <= i_req_unsigned;
            wdata_p0 <= i_req_wdata;
            err_p0   <= req_mis;
        end
    end

    // A faulting request spends its ACCESS cycle with the TCM deselected, so it keeps normal latency.
    always_comb begin
        state_d = state_q;
        req_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (i_req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                if (err_p0 || i_tcm_ack) state_d = RESP;
            end
            RESP: begin
                req_rdy = i_rsp_ready;
                if (i_rsp_ready) state_d = i_req_valid ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready = req_rdy & ~i_reset;
    assign accept      = i_req_valid & o_req_ready;

    // TCM drive stage.
    assign access      = (state_q == ACCESS) & ~err_p0 & ~i_reset;
    assign o_tcm_sel   = access;
    assign o_tcm_addr  = access ? addr_p0[AW-1:2] : '0;
    assign o_tcm_write = (access & we_p0) ? store_be(size_p0, addr_p0[1:0]) : 4'b0000;
    assign o_tcm_data  = (access & we_p0) ? store_data(size_p0, wdata_p0) : 32'b0;

    // Response stage: lane extraction straight off the TCM output register.
    assign resp        = (state_q == RESP) & ~i_reset;
    assign o_rsp_valid = resp;
    assign o_rsp_err   = resp & err_p0;
    assign o_rsp_data  = (resp & ~we_p0 & ~err_p0) ?
                         load_extract(size_p0, addr_p0[1:0], uns_p0, i_tcm_data) : 32'b0;

endmodule
